shift_unit_arbiter: RTL and testbench

//  Shares one 32-bit bidirectional barrel_shifter between NREQ requesters (ALU, address unit, test port).

---
 rtl/shift_pkg.sv | 18 +
 rtl/barrel_shifter.sv | 30 +++
 rtl/rr_picker.sv | 31 +++
 rtl/shift_unit_arbiter.sv | 112 +++++++++++
 tb/tb_shift_unit_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit: {dir,aorl} operation encodings,
// requester limit and the result-stage state type.
package shift_pkg;

  localparam logic [1:0] SHIFT_OP_LSR  = 2'b00;
  localparam logic [1:0] SHIFT_OP_ASR  = 2'b01;
  localparam logic [1:0] SHIFT_OP_LSL  = 2'b10;
  localparam logic [1:0] SHIFT_OP_PASS = 2'b11;

  localparam int unsigned NREQ_MAX = 8;

  // The result stage state is exactly rsp_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/barrel_shifter.sv
// 32-bit bidirectional barrel shifter; full 32-bit shift amount, saturating
// to zero (logical) or all sign bits (arithmetic right) for shamt >= 32.
module barrel_shifter
  import shift_pkg::*;
(
  input  logic [31:0] data,
  input  logic [31:0] shamt,
  input  logic        dir,
  input  logic        aorl,
  output logic [31:0] result
);

  logic       big;
  logic [4:0] amt;

  assign big = |shamt[31:5];
  assign amt = shamt[4:0];

  always_comb begin
    result = data;
    case ({dir, aorl})
      SHIFT_OP_LSR:  result = big ? '0 : (data >> amt);
      SHIFT_OP_ASR:  result = big ? {32{data[31]}} : 32'($signed(data) >>> amt);
      SHIFT_OP_LSL:  result = big ? '0 : (data << amt);
      SHIFT_OP_PASS: result = data;
      default:       result = data;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request searching from ptr upward,
// wrapping modulo NREQ. Returns one-hot grant, its index, and any-request.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // Candidate position ptr+k folded back into 0..NREQ-1 without a modulo.
      int unsigned j;
      j = 32'(ptr) + k;
      if (j >= 32'(NREQ)) j = j - 32'(NREQ);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Shares one barrel_shifter among NREQ requesters with round-robin grants and
// a single registered result stage using a valid/ready handshake.
module shift_unit_arbiter
  import shift_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [32*NREQ-1:0] req_shamt,
  input  logic [NREQ-1:0]    req_dir,
  input  logic [NREQ-1:0]    req_aorl,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        op_count
);

  rsp_state_t      state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] gidx;
  logic            any;
  logic            can_accept;
  logic            accept;
  logic [31:0]     sel_data, sel_shamt, shift_res;
  logic            sel_dir, sel_aorl;
  logic [31:0]     rsp_data_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [31:0]     op_count_q;

  rr_picker #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) u_picker (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (gidx),
    .any  (any)
  );

  // Winner operands via one-hot mux; all zero when nobody is requesting.
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    sel_dir   = 1'b0;
    sel_aorl  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_data  = req_data[32*i +: 32];
        sel_shamt = req_shamt[32*i +: 32];
        sel_dir   = req_dir[i];
        sel_aorl  = req_aorl[i];
      end
    end
  end

  barrel_shifter u_shifter (
    .data  (sel_data),
    .shamt (sel_shamt),
    .dir   (sel_dir),
    .aorl  (sel_aorl),
    .result(shift_res)
  );

  assign rr_ptr_nxt = (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_nxt  = state;
    can_accept = (state == EMPTY) || rsp_ready;
    req_ready  = (can_accept && rst_n) ? grant : '0;
    accept     = any && can_accept && rst_n;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (accept)         state_nxt = FULL;
        else if (rsp_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rr_ptr     <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_data_q <= shift_res;
        rsp_id_q   <= gidx;
        rr_ptr     <= rr_ptr_nxt;
        op_count_q <= op_count_q + 32'd1;
      end
    end
  end

  assign rsp_valid = (state == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter with hand-computed expected values.
module tb_shift_unit_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_data;
  logic [32*NREQ-1:0] req_shamt;
  logic [NREQ-1:0]    req_dir;
  logic [NREQ-1:0]    req_aorl;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        op_count;

  int nvec = 0;
  int nerr = 0;

  shift_unit_arbiter #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_shamt(req_shamt),
    .req_dir  (req_dir),
    .req_aorl (req_aorl),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] s,
                         input logic dir, input logic aorl);
    req_data[32*i +: 32]  = d;
    req_shamt[32*i +: 32] = s;
    req_dir[i]            = dir;
    req_aorl[i]           = aorl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // One operation through requester 0, result checked the cycle after accept.
  task automatic single(input string tag, input logic [31:0] d, input logic [31:0] s,
                        input logic dir, input logic aorl, input logic [31:0] exp);
    set_req(0, d, s, dir, aorl);
    req_valid = 4'b0001;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_id"}, 32'(rsp_id), 32'h0);
  endtask

  logic [ID_W-1:0] rr_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0]     rr_dat [5] = '{32'h11, 32'h22, 32'h44, 32'h88, 32'h11};

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    req_shamt = '0;
    req_dir   = '0;
    req_aorl  = '0;
    rsp_ready = 1'b1;

    // Reset state with every requester asking
    step();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_count", op_count, 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    req_valid = '0;
    rst_n     = 1'b1;
    step();

    // Single arithmetic right shift
    single("single", 32'h8000_0010, 32'd4, 1'b0, 1'b1, 32'hF800_0001);
    chk("single_cnt", op_count, 32'd1);
    step();
    chk("drain_vld", 32'(rsp_valid), 32'h0);
    chk("drain_hold", rsp_data, 32'hF800_0001);

    // Round-robin with all four requesting
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h11, 32'(i), 1'b1, 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_id%0d", k), 32'(rsp_id), 32'(rr_seq[k]));
      chk($sformatf("rr_data%0d", k), rsp_data, rr_dat[k]);
    end
    chk("rr_count", op_count, 32'd5);

    // Backpressure: result stalls, nothing granted
    rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      step();
      chk($sformatf("bp_vld%0d", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp_data%0d", k), rsp_data, 32'h11);
      chk($sformatf("bp_cnt%0d", k), op_count, 32'd5);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    chk("bp_next_id", 32'(rsp_id), 32'h1);
    chk("bp_next_data", rsp_data, 32'h22);
    chk("bp_next_cnt", op_count, 32'd6);
    req_valid = '0;

    // Shift boundaries
    do_reset();
    single("lsr32", 32'hFFFF_FFFF, 32'd32, 1'b0, 1'b0, 32'h0);
    single("asr40", 32'h8000_0000, 32'd40, 1'b0, 1'b1, 32'hFFFF_FFFF);
    single("pass", 32'h1234_5678, 32'd5, 1'b1, 1'b1, 32'h1234_5678);
    single("asr31", 32'h4000_0000, 32'd31, 1'b0, 1'b1, 32'h0);
    single("lsl4", 32'h0F00_00F1, 32'd4, 1'b1, 1'b0, 32'hF000_0F10);
    single("lsr_big", 32'hFFFF_FFFF, 32'h1000_0001, 1'b0, 1'b0, 32'h0);
    chk("bnd_cnt", op_count, 32'd6);
    step();

    // Async reset while stalled; rr_ptr must return to 0
    do_reset();
    set_req(1, 32'hA5A5_0000, 32'd8, 1'b0, 1'b0);
    set_req(3, 32'h0000_00FF, 32'd4, 1'b1, 1'b0);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    chk("stall_vld", 32'(rsp_valid), 32'h1);
    chk("stall_data", rsp_data, 32'h00A5_A500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(rsp_valid), 32'h0);
    chk("ar_cnt", op_count, 32'h0);
    req_valid = 4'b1010;
    #1;
    chk("ar_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("ar_first_grant", 32'(req_ready), 32'h2);
    step();
    chk("ar_first_id", 32'(rsp_id), 32'h1);
    chk("ar_first_cnt", op_count, 32'd1);
    chk("ar_next_grant", 32'(req_ready), 32'h8);
    step();
    chk("ar_second_id", 32'(rsp_id), 32'h3);
    chk("ar_second_data", rsp_data, 32'h0000_0FF0);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
